ingress_port_arbiter: RTL

Round-robin scheduler that shares the single packet-buffer write path among `NUM_PORTS` ingress CDC instances, all in the `clk_mem` domain. It watches each port's frame-ready handshake and grants one port at a time. It pulses that port's frame-start, then forwards the port's 128-bit word stream and frame header to the memory writer, and releases the grant on frame-done. It sits between the per-port ingress CDC outputs and the shared memory arbiter/writer.

---
 rtl/ingress_port_arbiter_pkg.sv | 15 +
 rtl/ingress_port_arbiter_if.sv | 28 ++
 rtl/ingress_port_arbiter_rr_priority_select.sv | 29 ++
 rtl/ingress_port_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ingress_port_arbiter_pkg.sv
// ingress_arb_pkg: shared state type, frame sizing constants and the byte-to-word helper
// Used by ingress_port_arbiter. Holds no ports.
package ingress_arb_pkg;

   typedef enum logic [1:0] {IDLE, START, BUSY} arb_state_t;

   localparam int WORD_BYTES      = 16;
   localparam int MAX_FRAME_WORDS = 96;

   // ceil(bytes / 16) for an 11-bit length, as a 7-bit word count
   function automatic logic [6:0] bytes_to_words(input logic [10:0] b);
      return b[10:4] + {6'd0, |b[3:0]};
   endfunction

endpackage

// File: rtl/ingress_port_arbiter_if.sv
// ingress_port_arbiter_if: downstream frame bus from the arbiter to the packet-buffer writer
// Signals: out_ready (writer -> arbiter), frame start/header, data strobe/word, frame done/length error.
// Modports: master = arbiter side, slave = writer side.
interface ingress_port_arbiter_if #(
   parameter int NUM_PORTS = 4
);
   logic                         out_ready;
   logic                         out_frame_start;
   logic [$clog2(NUM_PORTS)-1:0] out_port;
   logic [10:0]                  out_bytelen;
   logic [11:0]                  out_vlan;
   logic                         out_valid;
   logic [127:0]                 out_data;
   logic                         out_frame_done;
   logic                         out_len_error;

   modport master (
      input  out_ready,
      output out_frame_start, out_port, out_bytelen, out_vlan,
      output out_valid, out_data, out_frame_done, out_len_error
   );

   modport slave (
      output out_ready,
      input  out_frame_start, out_port, out_bytelen, out_vlan,
      input  out_valid, out_data, out_frame_done, out_len_error
   );
endinterface

// File: rtl/ingress_port_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin pick, first request above the last grant with wraparound
// Ports: req (request vector), last (previous grant index) -> gnt (one-hot), idx (index), any (a request won).
module rr_priority_select #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);
   logic [PW-1:0] p;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      p   = '0;
      for (int i = 1; i <= N; i++) begin
         p = PW'((int'(last) + i) % N);
         if (!any && req[p]) begin
            any    = 1'b1;
            gnt[p] = 1'b1;
            idx    = p;
         end
      end
   end
endmodule

// File: rtl/ingress_port_arbiter.sv
// ingress_port_arbiter: round-robin owner of the shared packet-buffer write path across ingress ports
// Ports: clk_mem, rst_n (async, active-low); port_frame_ready/bytelen/vlan, port_valid/data,
//   port_frame_done from each ingress CDC; port_frame_start one-hot grant pulse back to it;
//   ob (master modport) frame header/data/done bus to the writer; out_port_fault sticky faults.
// Optional watchdog: define INGRESS_ARB_WATCHDOG_EN to abort frames stuck in BUSY for TIMEOUT_CYCLES.
module ingress_port_arbiter
   import ingress_arb_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk_mem,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        port_frame_ready,
   input  logic [NUM_PORTS-1:0][10:0]  port_frame_bytelen,
   input  logic [NUM_PORTS-1:0][11:0]  port_frame_vlan,
   input  logic [NUM_PORTS-1:0]        port_valid,
   input  logic [NUM_PORTS-1:0][127:0] port_data,
   input  logic [NUM_PORTS-1:0]        port_frame_done,
   output logic [NUM_PORTS-1:0]        port_frame_start,
   ingress_port_arbiter_if.master      ob,
   output logic [NUM_PORTS-1:0]        out_port_fault
);
   localparam int PW = $clog2(NUM_PORTS);

   if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("ingress_port_arbiter: unsupported NUM_PORTS or TIMEOUT_CYCLES");
   end

   arb_state_t           state_q, state_d;
   logic [PW-1:0]        sel_q, last_q, rr_idx;
   logic [NUM_PORTS-1:0] gnt_q, rr_gnt, fault_q;
   logic                 rr_any, sel_valid, sel_done, timeout;
   logic [10:0]          bytelen_q;
   logic [11:0]          vlan_q;
   logic [6:0]           exp_q, beats_q, beats_next;
   logic                 valid_q, done_q, err_q;
   logic [127:0]         data_q;

   rr_priority_select #(.N(NUM_PORTS), .PW(PW)) u_rr (
      .req  (port_frame_ready & ~fault_q),
      .last (last_q),
      .gnt  (rr_gnt),
      .idx  (rr_idx),
      .any  (rr_any)
   );

   assign sel_valid  = port_valid[sel_q];
   assign sel_done   = port_frame_done[sel_q];
   assign beats_next = beats_q + 7'(sel_valid);

   always_comb begin
      state_d = state_q;
      state_d = (state_q == IDLE)  ? ((ob.out_ready && rr_any) ? START : IDLE) :
                (state_q == START) ? BUSY :
                (sel_done || timeout) ? IDLE : BUSY;
   end

   always_ff @(posedge clk_mem or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         last_q    <= PW'(NUM_PORTS - 1);
         gnt_q     <= '0;
         bytelen_q <= '0;
         vlan_q    <= '0;
         exp_q     <= '0;
         beats_q   <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         // data, done and error share one pipeline stage so done always trails the last word
         valid_q <= (state_q == BUSY) && sel_valid;
         done_q  <= (state_q == BUSY) && (sel_done || timeout);
         err_q   <= (state_q == BUSY) && (timeout || (sel_done && beats_next != exp_q));
         if (state_q == BUSY) data_q <= port_data[sel_q];
         if (state_q == BUSY) beats_q <= beats_next;
         if (state_q == IDLE && state_d == START) begin
            sel_q     <= rr_idx;
            gnt_q     <= rr_gnt;
            bytelen_q <= port_frame_bytelen[rr_idx];
            vlan_q    <= port_frame_vlan[rr_idx];
         end
         if (state_q == START) begin
            exp_q   <= bytes_to_words(bytelen_q);
            beats_q <= '0;
         end
         if (state_q == BUSY && state_d == IDLE) last_q <= sel_q;
      end
   end

`ifdef INGRESS_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;

   // a done on the final watchdog cycle still wins over the timeout
   assign timeout = (state_q == BUSY) && !sel_done && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_mem or negedge rst_n) begin
      if (!rst_n) begin
         wd_q    <= '0;
         fault_q <= '0;
      end else begin
         wd_q <= (state_q == START) ? '0 : (state_q == BUSY) ? wd_q + WD_W'(1) : wd_q;
         if (timeout) fault_q[sel_q] <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign fault_q = '0;
`endif

   assign port_frame_start   = (state_q == START) ? gnt_q : '0;
   assign ob.out_frame_start = (state_q == START);
   assign ob.out_port        = sel_q;
   assign ob.out_bytelen     = bytelen_q;
   assign ob.out_vlan        = vlan_q;
   assign ob.out_valid       = valid_q;
   assign ob.out_data        = data_q;
   assign ob.out_frame_done  = done_q;
   assign ob.out_len_error   = err_q;
   assign out_port_fault     = fault_q;
endmodule
